sram_mem_controller: RTL and testbench

Initiator side of the data-memory interface: takes the MEM-stage request (MEM_R_en/MEM_W_en, address, write data) and drives an external 16-bit asynchronous SRAM. Each 32-bit word is moved as two 16-bit half-accesses. Each half-access is held for a programmable number of wait cycles. Returns read data with a one-cycle ready pulse; the pipeline freezes on the freeze output while the access is in flight.

---
 rtl/sram_mem_controller.sv | 177 +++++++++++++++++
 tb/tb_sram_mem_controller.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_mem_controller.sv
// Data-memory initiator: moves each 32-bit MEM-stage word as two 16-bit
// half-accesses on an asynchronous SRAM, each held for WAIT_CYCLES clocks.
module sram_mem_controller #(
    parameter int WAIT_CYCLES = 2,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        addr_interface,
    input  logic [31:0]        data_in,
    input  logic               MEM_R_en,
    input  logic               MEM_W_en,
    output logic [31:0]        data_out,
    output logic               ready,
    output logic               freeze,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_wdata,
    input  logic [15:0]        sram_rdata,
    output logic               sram_we_n,
    output logic               sram_oe_n
);

    localparam int IW = SRAM_AW - 1;
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_LO,
        WR_HI,
        RD_LO,
        RD_HI,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [15:0]         whi_q, whi_d;
    logic [15:0]         rlo_q, rlo_d;
    logic [SRAM_AW-1:0]  addr_q, addr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                we_n_q, we_n_d;
    logic                oe_n_q, oe_n_d;
    logic                ready_q, ready_d;
    logic [31:0]         dout_q, dout_d;

    logic [IW-1:0]       req_idx;
    logic                last;
    logic                unused_addr_bits;

    assign req_idx          = addr_interface[SRAM_AW:2];
    assign last             = (cnt_q == CNT_LAST);
    assign unused_addr_bits = ^{addr_interface[31:SRAM_AW+1], addr_interface[1:0]};

    // Bus outputs are registered so they change only on clock edges and
    // stay glitch-free for the asynchronous SRAM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        whi_d   = whi_q;
        rlo_d   = rlo_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        ready_d = 1'b0;
        dout_d  = dout_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (MEM_W_en) begin
                    idx_d   = req_idx;
                    whi_d   = data_in[31:16];
                    addr_d  = {req_idx, 1'b0};
                    wdata_d = data_in[15:0];
                    we_n_d  = 1'b0;
                    state_d = WR_LO;
                end else if (MEM_R_en) begin
                    idx_d   = req_idx;
                    addr_d  = {req_idx, 1'b0};
                    oe_n_d  = 1'b0;
                    state_d = RD_LO;
                end
            end
            WR_LO: begin
                we_n_d = 1'b0;
                if (last) begin
                    cnt_d   = '0;
                    addr_d  = {idx_q, 1'b1};
                    wdata_d = whi_q;
                    state_d = WR_HI;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WR_HI: begin
                if (last) begin
                    cnt_d   = '0;
                    ready_d = 1'b1;
                    state_d = DONE;
                end else begin
                    we_n_d = 1'b0;
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            RD_LO: begin
                oe_n_d = 1'b0;
                if (last) begin
                    cnt_d   = '0;
                    rlo_d   = sram_rdata;
                    addr_d  = {idx_q, 1'b1};
                    state_d = RD_HI;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RD_HI: begin
                if (last) begin
                    cnt_d   = '0;
                    dout_d  = {sram_rdata, rlo_q};
                    ready_d = 1'b1;
                    state_d = DONE;
                end else begin
                    oe_n_d = 1'b0;
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            whi_q   <= '0;
            rlo_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            ready_q <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            whi_q   <= whi_d;
            rlo_q   <= rlo_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_n_q  <= we_n_d;
            oe_n_q  <= oe_n_d;
            ready_q <= ready_d;
            dout_q  <= dout_d;
        end
    end

    // Freeze drops in the ready cycle so the pipeline advances exactly once.
    assign freeze     = (MEM_R_en | MEM_W_en) & ~ready_q;
    assign ready      = ready_q;
    assign data_out   = dout_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign sram_we_n  = we_n_q;
    assign sram_oe_n  = oe_n_q;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: two instances (WAIT_CYCLES=2 and 1) on
// behavioural SRAMs, checked against a word-level reference memory.
`timescale 1ns/1ps
module tb_sram_mem_controller;
    localparam int AW = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] addr [2];
    logic [31:0] wdat [2];
    logic [31:0] dout [2];
    logic        r_en [2];
    logic        w_en [2];
    logic        rdy  [2];
    logic        frz  [2];
    logic        we_n [2];
    logic        oe_n [2];
    logic [AW-1:0] sa [2];
    logic [15:0] swd [2];
    logic [15:0] srd [2];

    sram_mem_controller #(.WAIT_CYCLES(2), .SRAM_AW(AW)) dut_a (
        .clk(clk), .rst(rst), .addr_interface(addr[0]), .data_in(wdat[0]),
        .MEM_R_en(r_en[0]), .MEM_W_en(w_en[0]), .data_out(dout[0]), .ready(rdy[0]),
        .freeze(frz[0]), .sram_addr(sa[0]), .sram_wdata(swd[0]), .sram_rdata(srd[0]),
        .sram_we_n(we_n[0]), .sram_oe_n(oe_n[0]));

    sram_mem_controller #(.WAIT_CYCLES(1), .SRAM_AW(AW)) dut_b (
        .clk(clk), .rst(rst), .addr_interface(addr[1]), .data_in(wdat[1]),
        .MEM_R_en(r_en[1]), .MEM_W_en(w_en[1]), .data_out(dout[1]), .ready(rdy[1]),
        .freeze(frz[1]), .sram_addr(sa[1]), .sram_wdata(swd[1]), .sram_rdata(srd[1]),
        .sram_we_n(we_n[1]), .sram_oe_n(oe_n[1]));

    // SRAM models: a write only lands once address and data have been held
    // with we_n low for the full wait time (write-pulse-width requirement).
    logic [15:0] sram0 [0:(1<<AW)-1];
    logic [15:0] sram1 [0:(1<<AW)-1];
    int run0_q = 0, run0_d, run1_q = 0, run1_d;
    logic [AW-1:0] wa0 = '0, wa1 = '0;
    logic [15:0] wd0 = '0, wd1 = '0;

    always_comb run0_d = we_n[0] ? 0 : ((run0_q != 0 && sa[0] == wa0 && swd[0] == wd0) ? run0_q + 1 : 1);
    always_comb run1_d = we_n[1] ? 0 : ((run1_q != 0 && sa[1] == wa1 && swd[1] == wd1) ? run1_q + 1 : 1);
    always @(posedge clk) begin
        run0_q <= run0_d; wa0 <= sa[0]; wd0 <= swd[0];
        if (run0_d == 2) sram0[sa[0]] <= swd[0];
    end
    always @(posedge clk) begin
        run1_q <= run1_d; wa1 <= sa[1]; wd1 <= swd[1];
        if (run1_d == 1) sram1[sa[1]] <= swd[1];
    end
    assign srd[0] = oe_n[0] ? 16'hFFFF : sram0[sa[0]];
    assign srd[1] = oe_n[1] ? 16'hFFFF : sram1[sa[1]];

    // Reference: word-level memory per unit and expected data_out per unit.
    logic [31:0] ref_mem [int];
    logic [31:0] ref_dout [2];
    int n_chk = 0, n_pass = 0;

    // Per-cycle trace of the last access (cycle 0 = acceptance cycle).
    logic [AW-1:0] t_sa [0:31];
    logic [15:0]   t_wd [0:31];
    logic          t_we [0:31], t_oe [0:31], t_fr [0:31];
    logic [31:0]   t_do [0:31];

    function automatic int wt(int u);
        return (u == 0) ? 2 : 1;
    endfunction
    function automatic int widx(logic [31:0] a);
        return int'((a >> 2) & 32'h1FFFF);
    endfunction
    function automatic int rkey(int u, int idx);
        return u * (1 << 20) + idx;
    endfunction
    function automatic logic [15:0] sram_rd(int u, int a);
        return (u == 0) ? sram0[a] : sram1[a];
    endfunction

    task automatic snap(input int u, input int k);
        t_sa[k] = sa[u]; t_wd[k] = swd[u]; t_we[k] = we_n[u];
        t_oe[k] = oe_n[u]; t_fr[k] = frz[u]; t_do[k] = dout[u];
    endtask

    // Issue one request, hold enables until ready, scramble addr/data after
    // acceptance to show the request was latched. rc = ready cycle or -1.
    task automatic run_acc(input int u, input logic w, input logic r,
                           input logic [31:0] a, input logic [31:0] d, output int rc);
        @(negedge clk);
        w_en[u] = w; r_en[u] = r; addr[u] = a; wdat[u] = d;
        #1 snap(u, 0);
        rc = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            snap(u, k);
            if (k == 1) begin addr[u] = $urandom; wdat[u] = $urandom; end
            if (rdy[u]) begin rc = k; break; end
        end
        w_en[u] = 1'b0; r_en[u] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        for (int u = 0; u < 2; u++) begin
            w_en[u] = 0; r_en[u] = 0; addr[u] = 0; wdat[u] = 0;
        end
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            n_chk++; if (rdy[u] !== 1'b0) $display("FAIL rst_ready u%0d: got %b want 0", u, rdy[u]); else n_pass++;
            n_chk++; if (dout[u] !== 32'h0) $display("FAIL rst_data_out u%0d: got %h want 0", u, dout[u]); else n_pass++;
            n_chk++; if (sa[u] !== '0) $display("FAIL rst_sram_addr u%0d: got %h want 0", u, sa[u]); else n_pass++;
            n_chk++; if (swd[u] !== 16'h0) $display("FAIL rst_sram_wdata u%0d: got %h want 0", u, swd[u]); else n_pass++;
            n_chk++; if (we_n[u] !== 1'b1 || oe_n[u] !== 1'b1) $display("FAIL rst_we_oe u%0d: got %b%b want 11", u, we_n[u], oe_n[u]); else n_pass++;
            n_chk++; if (frz[u] !== 1'b0) $display("FAIL rst_freeze u%0d: got %b want 0", u, frz[u]); else n_pass++;
            ref_dout[u] = 32'h0;
        end
        rst = 1'b1;
    endtask

    task automatic test_write;
        int rc;
        run_acc(0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, rc);
        ref_mem[rkey(0, widx(32'h100))] = 32'hDEADBEEF;
        n_chk++; if (rc !== 5) $display("FAIL wr_ready_cycle: got %0d want 5", rc); else n_pass++;
        for (int k = 1; k <= 4; k++) begin
            logic [AW-1:0] ea;
            logic [15:0] ed;
            ea = AW'(2 * widx(32'h100) + (k > 2 ? 1 : 0));
            ed = (k > 2) ? 16'hDEAD : 16'hBEEF;
            n_chk++; if (t_sa[k] !== ea || t_wd[k] !== ed) $display("FAIL wr_bus c%0d: got %h/%h want %h/%h", k, t_sa[k], t_wd[k], ea, ed); else n_pass++;
            n_chk++; if (t_we[k] !== 1'b0 || t_oe[k] !== 1'b1) $display("FAIL wr_strobes c%0d: got we%b oe%b want we0 oe1", k, t_we[k], t_oe[k]); else n_pass++;
        end
        for (int k = 0; k <= 5; k++) begin
            n_chk++; if (t_fr[k] !== (k < 5)) $display("FAIL wr_freeze c%0d: got %b want %b", k, t_fr[k], k < 5); else n_pass++;
        end
        n_chk++; if (t_we[5] !== 1'b1) $display("FAIL wr_done_we: got %b want 1", t_we[5]); else n_pass++;
        n_chk++; if (t_do[5] !== ref_dout[0]) $display("FAIL wr_data_out_hold: got %h want %h", t_do[5], ref_dout[0]); else n_pass++;
        n_chk++; if (sram0[18'h80] !== 16'hBEEF || sram0[18'h81] !== 16'hDEAD) $display("FAIL wr_sram: got %h %h want beef dead", sram0[18'h80], sram0[18'h81]); else n_pass++;
    endtask

    task automatic test_read;
        int rc;
        logic [31:0] d;
        run_acc(0, 1'b0, 1'b1, 32'h100, 32'h0, rc);
        ref_dout[0] = ref_mem[rkey(0, widx(32'h100))];
        n_chk++; if (rc !== 5) $display("FAIL rd_ready_cycle: got %0d want 5", rc); else n_pass++;
        for (int k = 1; k <= 4; k++) begin
            n_chk++; if (t_oe[k] !== 1'b0 || t_we[k] !== 1'b1) $display("FAIL rd_strobes c%0d: got oe%b we%b want oe0 we1", k, t_oe[k], t_we[k]); else n_pass++;
        end
        n_chk++; if (t_do[5] !== 32'hDEADBEEF) $display("FAIL rd_data: got %h want deadbeef", t_do[5]); else n_pass++;
        d = $urandom;
        run_acc(0, 1'b1, 1'b0, 32'h200, d, rc);
        ref_mem[rkey(0, widx(32'h200))] = d;
        @(negedge clk);
        n_chk++; if (dout[0] !== ref_dout[0]) $display("FAIL rd_hold_after_write: got %h want %h", dout[0], ref_dout[0]); else n_pass++;
    endtask

    task automatic test_both_enables;
        int rc, oe_lows;
        run_acc(0, 1'b1, 1'b1, 32'h8, 32'h12345678, rc);
        ref_mem[rkey(0, widx(32'h8))] = 32'h12345678;
        oe_lows = 0;
        for (int k = 1; k <= 5; k++) if (t_oe[k] === 1'b0) oe_lows++;
        n_chk++; if (rc !== 5) $display("FAIL both_ready_cycle: got %0d want 5", rc); else n_pass++;
        n_chk++; if (sram0[4] !== 16'h5678 || sram0[5] !== 16'h1234) $display("FAIL both_sram: got %h %h want 5678 1234", sram0[4], sram0[5]); else n_pass++;
        n_chk++; if (t_do[5] !== ref_dout[0]) $display("FAIL both_data_out: got %h want %h", t_do[5], ref_dout[0]); else n_pass++;
        n_chk++; if (oe_lows !== 0) $display("FAIL both_no_read: got %0d oe cycles want 0", oe_lows); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int stray;
        @(negedge clk);
        w_en[0] = 1'b1; addr[0] = 32'h100; wdat[0] = 32'hCAFEF00D;
        repeat (3) @(negedge clk);
        n_chk++; if (we_n[0] !== 1'b0 || sa[0] !== 18'h81) $display("FAIL rmid_in_wr_hi: got we%b addr %h want we0 addr 81", we_n[0], sa[0]); else n_pass++;
        rst = 1'b0; w_en[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        ref_dout[0] = 32'h0;
        ref_mem.delete(rkey(0, widx(32'h100)));
        n_chk++; if (we_n[0] !== 1'b1 || oe_n[0] !== 1'b1) $display("FAIL rmid_strobes: got we%b oe%b want 11", we_n[0], oe_n[0]); else n_pass++;
        n_chk++; if (rdy[0] !== 1'b0) $display("FAIL rmid_ready: got %b want 0", rdy[0]); else n_pass++;
        n_chk++; if (dout[0] !== 32'h0) $display("FAIL rmid_data_out: got %h want 0", dout[0]); else n_pass++;
        n_chk++; if (sa[0] !== '0) $display("FAIL rmid_sram_addr: got %h want 0", sa[0]); else n_pass++;
        stray = 0;
        repeat (8) begin
            @(negedge clk);
            if (rdy[0] !== 1'b0 || we_n[0] !== 1'b1) stray++;
        end
        n_chk++; if (stray !== 0) $display("FAIL rmid_idle_after: got %0d active cycles want 0", stray); else n_pass++;
        n_chk++; if (sram0[18'h81] !== 16'hDEAD) $display("FAIL rmid_hi_untouched: got %h want dead", sram0[18'h81]); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int rc, r1, r2, nr;
        logic [31:0] d0, d1;
        d0 = $urandom; d1 = $urandom;
        run_acc(0, 1'b1, 1'b0, 32'h0, d0, rc); ref_mem[rkey(0, 0)] = d0;
        run_acc(0, 1'b1, 1'b0, 32'h4, d1, rc); ref_mem[rkey(0, 1)] = d1;
        @(negedge clk);
        r_en[0] = 1'b1; addr[0] = 32'h0;
        r1 = -1; r2 = -1; nr = 0;
        for (int k = 1; k <= 40 && nr < 2; k++) begin
            @(negedge clk);
            if (rdy[0]) begin
                nr++;
                if (nr == 1) begin
                    r1 = k;
                    n_chk++; if (dout[0] !== ref_mem[rkey(0, 0)]) $display("FAIL b2b_first_data: got %h want %h", dout[0], ref_mem[rkey(0, 0)]); else n_pass++;
                    addr[0] = 32'h4;
                end else begin
                    r2 = k;
                    n_chk++; if (dout[0] !== ref_mem[rkey(0, 1)]) $display("FAIL b2b_second_data: got %h want %h", dout[0], ref_mem[rkey(0, 1)]); else n_pass++;
                end
            end
        end
        r_en[0] = 1'b0;
        ref_dout[0] = ref_mem[rkey(0, 1)];
        n_chk++; if (r1 !== 5) $display("FAIL b2b_first_ready: got %0d want 5", r1); else n_pass++;
        n_chk++; if (r2 - r1 !== 2 * wt(0) + 2) $display("FAIL b2b_spacing: got %0d want %0d", r2 - r1, 2 * wt(0) + 2); else n_pass++;
    endtask

    task automatic test_wait1;
        int rc;
        run_acc(1, 1'b1, 1'b0, 32'h3FC, 32'hA5A55A5A, rc);
        ref_mem[rkey(1, widx(32'h3FC))] = 32'hA5A55A5A;
        n_chk++; if (rc !== 3) $display("FAIL w1_wr_ready: got %0d want 3", rc); else n_pass++;
        n_chk++; if (t_sa[1] !== 18'h1FE || t_we[1] !== 1'b0 || t_sa[2] !== 18'h1FF || t_we[2] !== 1'b0) $display("FAIL w1_wr_bus: got %h/%b %h/%b want 1fe/0 1ff/0", t_sa[1], t_we[1], t_sa[2], t_we[2]); else n_pass++;
        n_chk++; if (sram1[18'h1FE] !== 16'h5A5A || sram1[18'h1FF] !== 16'hA5A5) $display("FAIL w1_sram: got %h %h want 5a5a a5a5", sram1[18'h1FE], sram1[18'h1FF]); else n_pass++;
        run_acc(1, 1'b0, 1'b1, 32'h3FC, 32'h0, rc);
        ref_dout[1] = ref_mem[rkey(1, widx(32'h3FC))];
        n_chk++; if (rc !== 3) $display("FAIL w1_rd_ready: got %0d want 3", rc); else n_pass++;
        n_chk++; if (t_oe[1] !== 1'b0 || t_oe[2] !== 1'b0 || t_oe[3] !== 1'b1) $display("FAIL w1_rd_oe: got %b%b%b want 001", t_oe[1], t_oe[2], t_oe[3]); else n_pass++;
        n_chk++; if (t_do[3] !== 32'hA5A55A5A) $display("FAIL w1_rd_data: got %h want a5a55a5a", t_do[3]); else n_pass++;
    endtask

    task automatic test_random;
        for (int it = 0; it < 30; it++) begin
            int u, op, idx, rc, lat, busy;
            logic [31:0] a, d;
            u   = $urandom_range(0, 1);
            op  = $urandom_range(0, 3);
            idx = 'h1000 + $urandom_range(0, 7);
            a   = (32'(idx) << 2) | 32'($urandom_range(0, 3));
            d   = $urandom;
            lat = 2 * wt(u) + 1;
            if (op == 1 && !ref_mem.exists(rkey(u, idx))) op = 0;
            if (op == 0 || op == 2) begin
                run_acc(u, 1'b1, op == 2, a, d, rc);
                ref_mem[rkey(u, idx)] = d;
                n_chk++; if (rc !== lat) $display("FAIL rnd_wr_ready it%0d: got %0d want %0d", it, rc, lat); else n_pass++;
                n_chk++; if (sram_rd(u, 2 * idx) !== d[15:0] || sram_rd(u, 2 * idx + 1) !== d[31:16]) $display("FAIL rnd_wr_sram it%0d: got %h%h want %h", it, sram_rd(u, 2 * idx + 1), sram_rd(u, 2 * idx), d); else n_pass++;
                n_chk++; if (t_do[lat] !== ref_dout[u]) $display("FAIL rnd_wr_hold it%0d: got %h want %h", it, t_do[lat], ref_dout[u]); else n_pass++;
            end else if (op == 1) begin
                run_acc(u, 1'b0, 1'b1, a, d, rc);
                ref_dout[u] = ref_mem[rkey(u, idx)];
                n_chk++; if (rc !== lat) $display("FAIL rnd_rd_ready it%0d: got %0d want %0d", it, rc, lat); else n_pass++;
                n_chk++; if (t_do[lat] !== ref_dout[u]) $display("FAIL rnd_rd_data it%0d: got %h want %h", it, t_do[lat], ref_dout[u]); else n_pass++;
            end else begin
                busy = 0;
                repeat (3) begin
                    @(negedge clk);
                    if (rdy[u] !== 1'b0 || frz[u] !== 1'b0 || we_n[u] !== 1'b1 || oe_n[u] !== 1'b1) busy++;
                end
                n_chk++; if (busy !== 0) $display("FAIL rnd_idle it%0d: got %0d busy cycles want 0", it, busy); else n_pass++;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        test_reset;
        test_write;
        test_read;
        test_both_enables;
        test_reset_mid;
        test_back_to_back;
        test_wait1;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
